// File: rtl/button_cond_pkg.sv
// button_cond_pkg: channel indices and default configuration shared by the
// button conditioner files.
package button_cond_pkg;

    localparam int CH_JOY_UP   = 0;
    localparam int CH_JOY_DOWN = 1;
    localparam int CH_ARCADE   = 2;

    localparam int         DEF_NUM_CH          = 3;
    localparam int         DEF_STABLE_CYCLES   = 50000;
    localparam logic [2:0] DEF_ACTIVE_LOW_MASK = 3'b100;
    localparam int         DEF_REPEAT_DELAY    = 12500000;
    localparam int         DEF_REPEAT_PERIOD   = 2500000;

endpackage

// File: rtl/debounce_channel.sv
// debounce_channel: one input channel with a synchronizer, debounce, press pulse and sticky latch.
// Auto-repeat pulses are added when BUTTON_COND_REPEAT_EN is defined.
module debounce_channel #(
    parameter int   STABLE_CYCLES = 50000,
    parameter logic ACTIVE_LOW    = 1'b0,
    parameter int   REPEAT_DELAY  = 12500000,
    parameter int   REPEAT_PERIOD = 2500000
) (
    input  logic clock,
    input  logic reset,
    input  logic raw_in,
    input  logic clear_inputs,
    output logic level,
    output logic press_pulse,
    output logic press_latched
);

    localparam int             CW       = $clog2(STABLE_CYCLES + 1);
    localparam logic [CW-1:0]  CNT_LAST = CW'(STABLE_CYCLES - 1);

    logic          s1, s2;
    logic [CW-1:0] cnt;
    logic          act, differ, accept, rise, repeat_hit;

    assign act    = s2 ^ ACTIVE_LOW;
    assign differ = act != level;
    assign accept = differ && cnt == CNT_LAST;
    assign rise   = accept && act;

    // Sync flops reset to the inactive pin level so release never looks like a press.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            s1            <= ACTIVE_LOW;
            s2            <= ACTIVE_LOW;
            cnt           <= '0;
            level         <= 1'b0;
            press_pulse   <= 1'b0;
            press_latched <= 1'b0;
        end else begin
            s1            <= raw_in;
            s2            <= s1;
            cnt           <= (!differ || accept) ? '0 : cnt + 1'b1;
            level         <= accept ? act : level;
            press_pulse   <= rise | repeat_hit;
            press_latched <= press_pulse | (press_latched & ~clear_inputs);
        end
    end

`ifdef BUTTON_COND_REPEAT_EN
    localparam int             HW       = $clog2(REPEAT_DELAY + 1);
    localparam logic [HW-1:0]  HOLD_HIT = HW'(REPEAT_DELAY - 1);
    localparam logic [HW-1:0]  HOLD_RLD = HW'(REPEAT_DELAY - REPEAT_PERIOD);

    logic [HW-1:0] hold;

    assign repeat_hit = level && !accept && hold == HOLD_HIT;

    // After the first repeat the counter reloads so it reaches the hit value every REPEAT_PERIOD.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            hold <= '0;
        else if (!level || accept)
            hold <= '0;
        else
            hold <= repeat_hit ? HOLD_RLD : hold + 1'b1;
    end

    if (STABLE_CYCLES < 1 || REPEAT_PERIOD < 1 || REPEAT_DELAY < REPEAT_PERIOD)
        $error("debounce_channel: invalid STABLE_CYCLES/REPEAT_DELAY/REPEAT_PERIOD");
`else
    assign repeat_hit = 1'b0;

    if (STABLE_CYCLES < 1 || REPEAT_DELAY < 0 || REPEAT_PERIOD < 0)
        $error("debounce_channel: STABLE_CYCLES must be at least 1");
`endif

endmodule

// File: rtl/button_conditioner.sv
// button_conditioner: NUM_CH independent debounced, active-high input channels.
// Define BUTTON_COND_REPEAT_EN to enable hold-to-repeat press pulses.
module button_conditioner
    import button_cond_pkg::*;
#(
    parameter int                NUM_CH          = DEF_NUM_CH,
    parameter int                STABLE_CYCLES   = DEF_STABLE_CYCLES,
    parameter logic [NUM_CH-1:0] ACTIVE_LOW_MASK = NUM_CH'(DEF_ACTIVE_LOW_MASK),
    parameter int                REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int                REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [NUM_CH-1:0] raw_in,
    input  logic              clear_inputs,
    output logic [NUM_CH-1:0] level,
    output logic [NUM_CH-1:0] press_pulse,
    output logic [NUM_CH-1:0] press_latched
);

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        debounce_channel #(
            .STABLE_CYCLES(STABLE_CYCLES),
            .ACTIVE_LOW   (ACTIVE_LOW_MASK[i]),
            .REPEAT_DELAY (REPEAT_DELAY),
            .REPEAT_PERIOD(REPEAT_PERIOD)
        ) u_ch (
            .clock        (clock),
            .reset        (reset),
            .raw_in       (raw_in[i]),
            .clear_inputs (clear_inputs),
            .level        (level[i]),
            .press_pulse  (press_pulse[i]),
            .press_latched(press_latched[i])
        );
    end

endmodule

// File: tb/tb_button_conditioner.sv
// tb_button_conditioner: directed checks of debounce latency, glitch rejection,
// latch set/clear priority, async reset and (optionally) auto-repeat.
module tb_button_conditioner;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic [2:0] raw_in = 3'b100;
    logic       clear_inputs = 1'b0;
    logic [2:0] level, press_pulse, press_latched;

    int n_checks = 0;
    int n_fail   = 0;

`ifdef BUTTON_COND_REPEAT_EN
    localparam bit REP = 1'b1;
`else
    localparam bit REP = 1'b0;
`endif

    button_conditioner #(
        .NUM_CH(3), .STABLE_CYCLES(4), .ACTIVE_LOW_MASK(3'b100),
        .REPEAT_DELAY(10), .REPEAT_PERIOD(3)
    ) dut (
        .clock(clock), .reset(reset), .raw_in(raw_in), .clear_inputs(clear_inputs),
        .level(level), .press_pulse(press_pulse), .press_latched(press_latched)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0; raw_in = 3'b100; clear_inputs = 1'b0;
        repeat (3) tick();
        n_checks++; if (level !== 3'b000) begin n_fail++; $display("FAIL reset_level: got %b expected 000", level); end
        n_checks++; if (press_pulse !== 3'b000) begin n_fail++; $display("FAIL reset_pulse: got %b expected 000", press_pulse); end
        n_checks++; if (press_latched !== 3'b000) begin n_fail++; $display("FAIL reset_latched: got %b expected 000", press_latched); end
        #2 reset = 1'b1;
        for (int e = 1; e <= 10; e++) begin
            tick();
            n_checks++; if (press_pulse !== 3'b000 || level !== 3'b000) begin n_fail++; $display("FAIL post_reset_quiet: edge %0d pulse %b level %b expected 000", e, press_pulse, level); end
        end
    endtask

    task automatic test_press();
        logic exp_l, exp_p, exp_q;
        raw_in[2] = 1'b0;
        for (int e = 1; e <= 8; e++) begin
            tick();
            exp_l = (e >= 6); exp_p = (e == 6); exp_q = (e >= 7);
            n_checks++; if (level[2] !== exp_l) begin n_fail++; $display("FAIL press_level: edge %0d got %b expected %b", e, level[2], exp_l); end
            n_checks++; if (press_pulse[2] !== exp_p) begin n_fail++; $display("FAIL press_pulse: edge %0d got %b expected %b", e, press_pulse[2], exp_p); end
            n_checks++; if (press_latched[2] !== exp_q) begin n_fail++; $display("FAIL press_latched: edge %0d got %b expected %b", e, press_latched[2], exp_q); end
        end
        repeat (3) tick();
        n_checks++; if (press_latched[2] !== 1'b1) begin n_fail++; $display("FAIL latch_hold: got %b expected 1", press_latched[2]); end
        clear_inputs = 1'b1;
        tick();
        clear_inputs = 1'b0;
        n_checks++; if (press_latched[2] !== 1'b0) begin n_fail++; $display("FAIL latch_clear: got %b expected 0", press_latched[2]); end
        raw_in[2] = 1'b1;
        for (int e = 1; e <= 8; e++) begin
            tick();
            n_checks++; if (press_pulse !== 3'b000) begin n_fail++; $display("FAIL release_pulse: edge %0d got %b expected 000", e, press_pulse); end
        end
        n_checks++; if (level[2] !== 1'b0) begin n_fail++; $display("FAIL release_level: got %b expected 0", level[2]); end
    endtask

    task automatic test_bounce();
        int   pulses;
        logic exp_l;
        pulses = 0;
        raw_in[0] = 1'b1; tick(); tick();
        raw_in[0] = 1'b0; tick(); tick();
        n_checks++; if (level[0] !== 1'b0) begin n_fail++; $display("FAIL bounce_mid_level: got %b expected 0", level[0]); end
        raw_in[0] = 1'b1;
        for (int e = 1; e <= 8; e++) begin
            tick();
            if (press_pulse[0]) pulses++;
            exp_l = (e >= 6);
            n_checks++; if (level[0] !== exp_l) begin n_fail++; $display("FAIL bounce_level: edge %0d got %b expected %b", e, level[0], exp_l); end
        end
        n_checks++; if (pulses !== 1) begin n_fail++; $display("FAIL bounce_pulses: got %0d expected 1", pulses); end
        raw_in[0] = 1'b0;
        repeat (8) tick();
        clear_inputs = 1'b1; tick(); clear_inputs = 1'b0;
    endtask

    task automatic test_set_clear();
        raw_in[1] = 1'b1;
        repeat (5) tick();
        n_checks++; if (press_pulse[1] !== 1'b0) begin n_fail++; $display("FAIL sc_early_pulse: got %b expected 0", press_pulse[1]); end
        tick();
        n_checks++; if (press_pulse[1] !== 1'b1) begin n_fail++; $display("FAIL sc_pulse: got %b expected 1", press_pulse[1]); end
        clear_inputs = 1'b1;
        tick();
        n_checks++; if (press_latched[1] !== 1'b1) begin n_fail++; $display("FAIL sc_set_wins: got %b expected 1", press_latched[1]); end
        n_checks++; if (press_pulse[1] !== 1'b0) begin n_fail++; $display("FAIL sc_pulse_width: got %b expected 0", press_pulse[1]); end
        tick();
        clear_inputs = 1'b0;
        n_checks++; if (press_latched[1] !== 1'b0) begin n_fail++; $display("FAIL sc_clear: got %b expected 0", press_latched[1]); end
        raw_in[1] = 1'b0;
        repeat (8) tick();
    endtask

    task automatic test_reset_mid();
        logic [2:0] exp_p;
        logic       exp_l;
        raw_in[1] = 1'b1;
        repeat (8) tick();
        raw_in[0] = 1'b1;
        repeat (5) tick();
        n_checks++; if (level !== 3'b010 || press_latched !== 3'b010) begin n_fail++; $display("FAIL pre_reset_state: level %b latched %b expected 010", level, press_latched); end
        reset = 1'b0;
        #1;
        n_checks++; if (level !== 3'b000) begin n_fail++; $display("FAIL async_reset_level: got %b expected 000", level); end
        n_checks++; if (press_latched !== 3'b000 || press_pulse !== 3'b000) begin n_fail++; $display("FAIL async_reset_flags: latched %b pulse %b expected 000", press_latched, press_pulse); end
        #3 reset = 1'b1;
        for (int e = 1; e <= 7; e++) begin
            tick();
            exp_l = (e >= 6);
            exp_p = (e == 6) ? 3'b011 : 3'b000;
            n_checks++; if (level[0] !== exp_l || level[1] !== exp_l) begin n_fail++; $display("FAIL restart_level: edge %0d got %b expected %b on ch0/ch1", e, level, exp_l); end
            n_checks++; if (press_pulse !== exp_p) begin n_fail++; $display("FAIL restart_pulse: edge %0d got %b expected %b", e, press_pulse, exp_p); end
        end
        raw_in[1:0] = 2'b00;
        repeat (8) tick();
        clear_inputs = 1'b1; tick(); clear_inputs = 1'b0;
    endtask

    task automatic test_repeat();
        logic exp_p;
        raw_in[1] = 1'b1;
        repeat (6) tick();
        for (int h = 0; h < 30; h++) begin
            exp_p = (h == 0) || (REP && h >= 10 && (h - 10) % 3 == 0);
            n_checks++; if (press_pulse[1] !== exp_p) begin n_fail++; $display("FAIL repeat_pulse: hold cycle %0d got %b expected %b", h, press_pulse[1], exp_p); end
            tick();
        end
        n_checks++; if (level[1] !== 1'b1 || press_latched[1] !== 1'b1) begin n_fail++; $display("FAIL repeat_hold: level %b latched %b expected 1/1", level[1], press_latched[1]); end
        raw_in[1] = 1'b0;
        repeat (8) tick();
        n_checks++; if (level[1] !== 1'b0) begin n_fail++; $display("FAIL repeat_release: got %b expected 0", level[1]); end
    endtask

    initial begin
        test_reset();
        test_press();
        test_bounce();
        test_set_clear();
        test_reset_mid();
        test_repeat();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/button_conditioner.md
Name: button_conditioner

Overview:
- Multi-channel input conditioner between the raw board pins (joystick up/down, arcade button) and the user-interface stage.
- Per channel:
  - 2-flop synchronizer
  - polarity normalization
  - counter-based debounce
  - one-cycle press pulse
  - sticky press latch held until the game FSM asserts clear_inputs
- All outputs are active-high, debounced and glitch-free. Downstream logic consumes them directly.

Parameters:
- NUM_CH, 3, number of input channels (0 = JOY_UP, 1 = JOY_DOWN, 2 = ARCADE_BUTTON).
- STABLE_CYCLES, 50000, consecutive stable cycles required to accept a level change (1 ms at 50 MHz); must be >= 1.
- ACTIVE_LOW_MASK, 3'b100, bit i = 1 means raw_in[i] is active-low (arcade button pulls low).
- REPEAT_DELAY, 12500000, hold cycles before first auto-repeat pulse (optional feature only).
- REPEAT_PERIOD, 2500000, cycles between subsequent auto-repeat pulses (optional feature only).

Ports:
- clock  input  1  system clock
- reset  input  1  asynchronous, active-low reset; all state clears while reset == 0
- raw_in  input  NUM_CH  asynchronous raw pin levels
- clear_inputs  input  1  synchronous clear of all press_latched bits
- level  output  NUM_CH  debounced, active-high pressed state
- press_pulse  output  NUM_CH  one-cycle pulse per accepted press (plus repeats if enabled)
- press_latched  output  NUM_CH  sticky press flag, held until clear_inputs

Behaviour:
- Reset (reset == 0, async):
  - Sync flops load the inactive raw value (1 for active-low channels, 0 otherwise), so no false press at release.
  - Counters = 0; level, press_pulse and press_latched = 0.
- Synchronizer: raw_in -> s1 -> s2, registered each clock. act[i] = s2[i] XOR ACTIVE_LOW_MASK[i].
- Debounce counter, per channel, width $clog2(STABLE_CYCLES+1):
  - If act == level: counter <= 0.
  - Else if counter == STABLE_CYCLES-1: level <= act, counter <= 0.
  - Else: counter <= counter + 1.
- Latency: a raw change held stable reaches level exactly STABLE_CYCLES+2 rising edges after the first edge that samples it.
- Glitch rejection: any bounce shorter than STABLE_CYCLES cycles resets the counter; level does not change.
- STABLE_CYCLES = 1: level follows act with one register delay.
- press_pulse[i]:
  - Registered; high for exactly the one cycle in which level[i] has just risen (same edge as the level 0->1 update).
  - Never asserted on release.
- press_latched[i]:
  - Set when press_pulse[i] = 1.
  - Cleared on a clock edge with clear_inputs = 1.
  - Set and clear on the same edge: set wins, so no press is lost.
- Channels are fully independent. Simultaneous presses on several channels pulse together.
- Reset asserted mid-debounce: the partial count is discarded; after release, debounce restarts from 0.

Optional Feature:
- Macro BUTTON_COND_REPEAT_EN.
- Defined:
  - Per-channel hold counter runs while level[i] = 1.
  - Extra press_pulse when held for REPEAT_DELAY cycles, then every REPEAT_PERIOD cycles.
  - Extra pulses also set press_latched.
  - Hold counter zeroes when level falls or on reset.
- Undefined:
  - No hold counters are synthesized; exactly one pulse per press.
  - REPEAT_* parameters are ignored.

Decomposition:
- Package button_cond_pkg:
  - channel index constants CH_JOY_UP = 0, CH_JOY_DOWN = 1, CH_ARCADE = 2
  - default NUM_CH, STABLE_CYCLES and ACTIVE_LOW_MASK
- Sub-module debounce_channel:
  - one channel: synchronizer, counter, level, pulse, latch and optional repeat
  - instantiated NUM_CH times in a generate loop by button_conditioner

Test Plan (sim with STABLE_CYCLES = 4, REPEAT_DELAY = 10, REPEAT_PERIOD = 3):
- Reset with raw_in = 3'b100 -> all outputs 0; no pulse after reset deasserts.
- raw_in[2] driven 1 -> 0 and held -> level[2] = 1 exactly 6 edges later; press_pulse[2] high for 1 cycle; press_latched[2] = 1 until clear_inputs.
- raw_in[0] bounces 0-1-0-1 at 2-cycle intervals, then held 1 -> level[0] rises only 6 edges after the final transition; exactly one pulse.
- press_pulse[1] and clear_inputs on the same edge -> press_latched[1] = 1 afterward; clear_inputs alone on the next edge -> 0.
- reset dropped to 0 with channel 0's counter at 3 -> outputs 0 immediately; after release, a held press needs a full 6 edges again.
- BUTTON_COND_REPEAT_EN defined, channel 1 held 30 cycles after level rises -> pulses at hold cycles 0, 10, 13, 16, ..., 28; with the macro undefined, only the cycle-0 pulse.
